// File: rtl/issue_pick_sched.sv
// Oldest-ready issue scheduler for a 4-entry window: age matrix, pipe/ordering checks, one-hot grant.
// ISSUE_PICK_SCHED_MUL_BLOCKING_EN builds the MUL occupancy counter; otherwise MUL is treated as fully pipelined.
module issue_pick_sched #(
  parameter int MUL_LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_alloc,
  input  logic [3:0] i_valid,
  input  logic [3:0] i_src0_rdy,
  input  logic [3:0] i_src1_rdy,
  input  logic [3:0] i_load,
  input  logic [3:0] i_store,
  input  logic [3:0] i_pipe_alu,
  input  logic [3:0] i_pipe_mul,
  input  logic [3:0] i_pipe_mem,
  input  logic [3:0] i_pipe_bru,
  input  logic       i_mem_ready,
  input  logic       snoop_hit,
  input  logic       bco_valid,
  output logic [3:0] o_en,
  output logic       o_valid,
  output logic [1:0] o_pick,
  output logic [3:0] o_pipe,
  output logic       o_mul_busy
);

  // age_reg[i][j] = 1 means entry i is older than entry j
  logic [3:0][3:0] age_reg;
  logic [3:0][3:0] age_next;
  logic [3:0][3:0] older_mask;  // older_mask[i][j] = age_reg[j][i]
  logic [3:0]      pipe_ok;
  logic [3:0]      ord_block;
  logic [3:0]      eligible;
  logic [3:0]      blocked;
  logic [3:0]      win;
  logic [3:0]      lowest;
  logic [3:0]      grant;
  logic [3:0]      pipe_sel;
  logic [1:0]      pick_idx;
  logic            mul_free;

  always_comb begin
    age_next = age_reg;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i_alloc[i]) begin
          // new occupant is younger than everything except higher-index co-allocations
          age_next[i][j] = i_alloc[j] && (j > i);
        end else if (i_alloc[j] && (j != i)) begin
          age_next[i][j] = i_valid[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      age_reg <= '0;
    end else begin
      age_reg <= age_next;
    end
  end

  always_comb begin
    older_mask = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        older_mask[i][j] = age_reg[j][i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      assign pipe_ok[gi] = i_pipe_alu[gi] | i_pipe_bru[gi]
                         | (i_pipe_mul[gi] & mul_free)
                         | (i_pipe_mem[gi] & i_mem_ready & ~(i_load[gi] & snoop_hit));
      assign ord_block[gi] = i_load[gi] & |(older_mask[gi] & i_store & i_valid);
      assign eligible[gi]  = i_valid[gi] & i_src0_rdy[gi] & i_src1_rdy[gi]
                           & pipe_ok[gi] & ~ord_block[gi] & ~bco_valid;
      assign blocked[gi]   = |(older_mask[gi] & eligible);
    end
  endgenerate

  assign win    = eligible & ~blocked;
  assign lowest = eligible & (~eligible + 4'd1);

  // Falls back to the lowest eligible index if the age order is ever not a clean total order
  always_comb begin
    if ((win != 4'd0) && ((win & (win - 4'd1)) == 4'd0)) begin
      grant = win;
    end else begin
      grant = lowest;
    end
  end

  assign o_en = reset ? 4'd0 : grant;

  always_comb begin
    pipe_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (o_en[i]) begin
        pipe_sel = pipe_sel | {i_pipe_bru[i], i_pipe_mem[i], i_pipe_mul[i], i_pipe_alu[i]};
      end
    end
  end

  always_comb begin
    pick_idx = 2'd0;
    if (o_en[3])      pick_idx = 2'd3;
    else if (o_en[2]) pick_idx = 2'd2;
    else if (o_en[1]) pick_idx = 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_pick  <= 2'd0;
      o_pipe  <= 4'd0;
    end else begin
      o_valid <= |o_en;
      o_pick  <= pick_idx;
      o_pipe  <= pipe_sel;
    end
  end

`ifdef ISSUE_PICK_SCHED_MUL_BLOCKING_EN
  logic [2:0] mul_cnt_reg;
  logic       mul_grant;

  assign mul_grant = |(o_en & i_pipe_mul);

  // A flushed MUL still occupies the pipe, so bco_valid does not clear the count
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt_reg <= 3'd0;
    end else if (mul_grant) begin
      mul_cnt_reg <= 3'(MUL_LATENCY - 1);
    end else if (mul_cnt_reg != 3'd0) begin
      mul_cnt_reg <= mul_cnt_reg - 3'd1;
    end
  end

  assign mul_free   = (mul_cnt_reg == 3'd0);
  assign o_mul_busy = ~mul_free;
`else
  // Fully pipelined multiplier: any legal latency (>= 1) accepts an op every cycle
  assign mul_free   = (MUL_LATENCY > 0);
  assign o_mul_busy = 1'b0;
`endif

endmodule

// File: tb/tb_issue_pick_sched.sv
// Randomized bench for issue_pick_sched against an age-ordered queue model of the window.
module tb_issue_pick_sched;
  localparam int MUL_LAT = 3;
`ifdef ISSUE_PICK_SCHED_MUL_BLOCKING_EN
  localparam bit MUL_BLK = 1'b1;
`else
  localparam bit MUL_BLK = 1'b0;
`endif
  localparam int K_ALU = 0, K_MUL = 1, K_LD = 2, K_ST = 3, K_BRU = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] i_alloc, i_valid, i_src0_rdy, i_src1_rdy, i_load, i_store;
  logic [3:0] i_pipe_alu, i_pipe_mul, i_pipe_mem, i_pipe_bru;
  logic       i_mem_ready, snoop_hit, bco_valid;
  logic [3:0] o_en;
  logic       o_valid;
  logic [1:0] o_pick;
  logic [3:0] o_pipe;
  logic       o_mul_busy;

  issue_pick_sched #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .i_alloc(i_alloc), .i_valid(i_valid),
    .i_src0_rdy(i_src0_rdy), .i_src1_rdy(i_src1_rdy), .i_load(i_load), .i_store(i_store),
    .i_pipe_alu(i_pipe_alu), .i_pipe_mul(i_pipe_mul), .i_pipe_mem(i_pipe_mem),
    .i_pipe_bru(i_pipe_bru), .i_mem_ready(i_mem_ready), .snoop_hit(snoop_hit),
    .bco_valid(bco_valid), .o_en(o_en), .o_valid(o_valid), .o_pick(o_pick),
    .o_pipe(o_pipe), .o_mul_busy(o_mul_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Window model: valid entries kept in a queue, oldest first
  bit vld[4];
  int kind[4];
  int order[$];
  int cyc = 0;
  int mul_ready_cyc = 0;
  bit exp_valid = 1'b0;
  int exp_pick = 0;
  int exp_pipe = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pipe_bits(input int k);
    case (k)
      K_ALU:      return 1;
      K_MUL:      return 2;
      K_LD, K_ST: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic void remove_entry(input int e);
    for (int q = 0; q < order.size(); q++) begin
      if (order[q] == e) begin
        order.delete(q);
        break;
      end
    end
  endfunction

  task automatic run_cycle(input bit rst);
    int g;
    int new_kind[4];
    bit ok;
    bit older_store;
    int e;
    check_val("o_valid", 32'(o_valid), 32'(exp_valid));
    check_val("o_pick", 32'(o_pick), 32'(exp_pick));
    check_val("o_pipe", 32'(o_pipe), 32'(exp_pipe));
    check_val("o_mul_busy", 32'(o_mul_busy), 32'(MUL_BLK && (cyc < mul_ready_cyc)));

    reset       = rst;
    bco_valid   = ($urandom % 10) == 0;
    snoop_hit   = ($urandom % 5) == 0;
    i_mem_ready = ($urandom % 5) != 0;
    for (int i = 0; i < 4; i++) begin
      i_valid[i]    = vld[i];
      i_src0_rdy[i] = ($urandom % 4) != 0;
      i_src1_rdy[i] = ($urandom % 4) != 0;
      i_pipe_alu[i] = kind[i] == K_ALU;
      i_pipe_mul[i] = kind[i] == K_MUL;
      i_pipe_mem[i] = (kind[i] == K_LD) || (kind[i] == K_ST);
      i_pipe_bru[i] = kind[i] == K_BRU;
      i_load[i]     = kind[i] == K_LD;
      i_store[i]    = kind[i] == K_ST;
    end

    // Oldest qualifying entry wins
    g = -1;
    older_store = 1'b0;
    if (!rst && !bco_valid) begin
      foreach (order[q]) begin
        e = order[q];
        case (kind[e])
          K_MUL:   ok = !MUL_BLK || (cyc >= mul_ready_cyc);
          K_LD:    ok = i_mem_ready && !snoop_hit && !older_store;
          K_ST:    ok = i_mem_ready;
          default: ok = 1'b1;
        endcase
        if (ok && i_src0_rdy[e] && i_src1_rdy[e]) begin
          g = e;
          break;
        end
        if (kind[e] == K_ST) older_store = 1'b1;
      end
    end

    i_alloc = 4'd0;
    for (int i = 0; i < 4; i++) begin
      new_kind[i] = $urandom_range(4);
      if (!rst && (!vld[i] || i == g) && ($urandom % 3) == 0) i_alloc[i] = 1'b1;
    end

    #1;
    check_val("o_en", 32'(o_en), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);

    if (rst) begin
      for (int i = 0; i < 4; i++) vld[i] = 1'b0;
      order.delete();
      mul_ready_cyc = 0;
      exp_valid = 1'b0;
      exp_pick  = 0;
      exp_pipe  = 0;
    end else begin
      exp_valid = g >= 0;
      exp_pick  = (g >= 0) ? g : 0;
      exp_pipe  = (g >= 0) ? pipe_bits(kind[g]) : 0;
      if (g >= 0) begin
        if (kind[g] == K_MUL) mul_ready_cyc = cyc + MUL_LAT;
        vld[g] = 1'b0;
        remove_entry(g);
      end
      for (int i = 0; i < 4; i++) begin
        if (i_alloc[i]) begin
          remove_entry(i);
          order.push_back(i);
          vld[i]  = 1'b1;
          kind[i] = new_kind[i];
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {i_alloc, i_valid, i_src0_rdy, i_src1_rdy, i_load, i_store} = '0;
    {i_pipe_alu, i_pipe_mul, i_pipe_mem, i_pipe_bru} = '0;
    {i_mem_ready, snoop_hit, bco_valid} = '0;
    for (int i = 0; i < 4; i++) begin
      vld[i]  = 1'b0;
      kind[i] = K_ALU;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 800; n++) begin
      run_cycle((n % 200) >= 190 && (n % 200) < 192);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
